imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered immediate generator with a valid/ready handshake, for the decode stage of the pipelined RV32/RV64 core. It takes instruction bits [31:7] and an immediate-format select, and produces the sign-extended immediate one cycle later. It is parametrised in output width and in a sideband tag that travels with the immediate. A 2-entry skid buffer lets it absorb backpressure without a combinational in_ready path.

## Interface
- WIDTH, 32, immediate output width; legal values are 32 and 64
- TAG_W, 5, width of the sideband tag (e.g. rd index or PC slice); minimum 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat
- instr  in  25  instruction bits [31:7]; instr[i] = Instr[i+7]
- imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR), 110/111 reserved
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts output
- imm_ext  out  WIDTH  extended immediate
- out_tag  out  TAG_W  tag of the output beat
- out_illegal  out  1  imm_src was reserved or disabled for this beat

## Operation
- Formats (Instr numbering):
  - I = sext(Instr[31:20])
  - S = sext({Instr[31:25],Instr[11:7]})
  - B = sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0})
  - J = sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],1'b0})
  - U = sext({Instr[31:12],12'b0})
  - Z = zext(Instr[19:15])
- Sign extension is always from Instr[31] to WIDTH bits; U-type with WIDTH=64 is sign-extended from bit 31.
- Codes 000–011 match the legacy 2-bit ImmSrc encoding.
- Reserved or disabled code: imm_ext=0, out_illegal=1. The beat is still delivered; it is not dropped.
- Storage: main register (drives outputs) plus one skid register.
- Input transfer: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- in_ready is registered and equals !skid_valid.
- When main is empty or draining, the incoming beat loads main.
- When main is held (out_valid && !out_ready), the incoming beat loads skid.
- When main drains and skid is full, skid moves into main and skid empties.
- flush clears both valid bits. It has priority over a same-cycle input transfer; that beat is discarded.

## Timing
- Reset values: out_valid=0, in_ready=1, imm_ext=0, out_tag=0, out_illegal=0, skid empty.
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- Output payload is stable while out_valid && !out_ready.
- in_ready falls the cycle after skid fills and rises the cycle after skid drains.
- Input and output transfer in the same cycle keeps occupancy unchanged.
- Reset asserted mid-stream: both entries are lost immediately (asynchronous); outputs return to reset values.
- flush: out_valid=0 and in_ready=1 on the next cycle. Payload registers may hold stale data.

## Configuration
- Macro: IMM_GEN_CSR_EN.
- Defined: code 101 produces the Z format, out_illegal=0.
- Undefined: code 101 is treated as reserved (imm_ext=0, out_illegal=1); no Z-format logic is synthesised.

## Structure
- Shared package imm_pkg holds:
  - the imm_src enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z)
  - the payload struct {imm, tag, illegal}
- Sub-module imm_decode: purely combinational format mux and extension, parametrised by WIDTH.
- imm_gen_pipe contains only the skid-buffer control and registers.

## Test plan
- Legacy regression: instr=0x0000014 with imm_src 000/001/010/011 -> 0x00000000 / 0x00000014 / 0x00000014 / 0x00000000.
- addi field instr=0x1FFE001, imm_src=000 -> 0xFFFFFFFF; B field instr=0x1FC001D, imm_src=010 -> 0xFFFFFFFC; both with out_valid one cycle after transfer.
- U field instr=0x02468A1, imm_src=100, WIDTH=64 -> 0x0000000012345000. Set instr[24]=1 -> upper 32 bits all ones.
- Backpressure: stream 4 beats with out_ready=0 -> 2 accepted, in_ready=0 from cycle 3. Then raise out_ready -> beats emerge in order with matching tags, none lost or duplicated.
- flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle beat never appears.
- imm_src=110 -> out_illegal=1, imm_ext=0. imm_src=101, instr[12:8]=0x1F -> 0x1F with IMM_GEN_CSR_EN defined, illegal without it.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format-select encoding.
// Codes 000-011 keep the legacy 2-bit ImmSrc values; 110/111 are reserved.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: format mux plus sign/zero extension to WIDTH.
// The Z (CSR) format exists only when IMM_GEN_CSR_EN is defined; otherwise code 101 is reserved.
module imm_decode
  import imm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  output logic [WIDTH-1:0] imm,
  output logic             illegal
);

  // 32-bit signed forms; the WIDTH cast below extends them from Instr[31].
  logic signed [31:0] w_i;
  logic signed [31:0] w_s;
  logic signed [31:0] w_b;
  logic signed [31:0] w_j;
  logic signed [31:0] w_u;

  assign w_i = {{20{instr[24]}}, instr[24:13]};
  assign w_s = {{20{instr[24]}}, instr[24:18], instr[4:0]};
  assign w_b = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
  assign w_j = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
  assign w_u = {instr[24:5], 12'b0};

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I:   imm = WIDTH'(w_i);
      IMM_S:   imm = WIDTH'(w_s);
      IMM_B:   imm = WIDTH'(w_b);
      IMM_J:   imm = WIDTH'(w_j);
      IMM_U:   imm = WIDTH'(w_u);
`ifdef IMM_GEN_CSR_EN
      IMM_Z:   imm = WIDTH'(instr[12:8]);
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator, 1-cycle latency, 1 beat/cycle; a 2-entry skid keeps in_ready a flop.
// Build option IMM_GEN_CSR_EN enables the Z (CSR) format on code 101.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } payload_t;

  logic [WIDTH-1:0] w_dec_imm;
  logic             w_dec_illegal;
  payload_t         w_in_beat;
  payload_t         r_main;
  payload_t         r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;

  logic w_in_xfer;
  logic w_main_open;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_skid_ld;
  logic w_main_vld_nxt;
  logic w_skid_vld_nxt;

  imm_decode #(.WIDTH(WIDTH)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (w_dec_imm),
    .illegal (w_dec_illegal)
  );

  assign w_in_beat = {w_dec_imm, in_tag, w_dec_illegal};

  assign in_ready    = ~r_skid_vld;
  assign w_in_xfer   = in_valid & in_ready;
  assign w_main_open = ~r_main_vld | out_ready;

  // Skid can only be full while main is full, so in_ready=0 whenever skid refills main.
  always_comb begin
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    if (flush) begin
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (w_main_open) begin
      if (r_skid_vld) begin
        w_main_ld_skid = 1'b1;
        w_main_vld_nxt = 1'b1;
        w_skid_vld_nxt = 1'b0;
      end else begin
        w_main_ld_in   = w_in_xfer;
        w_main_vld_nxt = w_in_xfer;
      end
    end else if (w_in_xfer) begin
      w_skid_ld      = 1'b1;
      w_skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      if (w_main_ld_skid) begin
        r_main <= r_skid;
      end else if (w_main_ld_in) begin
        r_main <= w_in_beat;
      end
      if (w_skid_ld) begin
        r_skid <= w_in_beat;
      end
    end
  end

  assign out_valid   = r_main_vld;
  assign imm_ext     = r_main.imm;
  assign out_tag     = r_main.tag;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances share stimulus; a queue model tracks occupancy and payload.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_CSR_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [24:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  in_tag;

  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .imm_ext(imm32), .out_tag(tag32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.WIDTH(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .imm_ext(imm64), .out_tag(tag64), .out_illegal(ill64)
  );

  // Reference: rebuild the 32-bit instruction word and apply the format equations arithmetically.
  function automatic longint sx(longint v, int n);
    if (((v >>> (n - 1)) & 64'sd1) != 0) return v - (64'sd1 <<< n);
    return v;
  endfunction

  function automatic logic ref_ill(logic [2:0] src);
    return (src > 3'd5) || (src == 3'd5 && !CSR_EN);
  endfunction

  function automatic logic [63:0] ref_imm(logic [24:0] ins, logic [2:0] src);
    logic [31:0] x;
    longint r;
    x = {ins, 7'b0};
    case (src)
      3'd0: r = sx(longint'(x[31:20]), 12);
      3'd1: r = sx(longint'({x[31:25], x[11:7]}), 12);
      3'd2: r = sx(longint'({x[31], x[7], x[30:25], x[11:8], 1'b0}), 13);
      3'd3: r = sx(longint'({x[31], x[19:12], x[20], x[30:21], 1'b0}), 21);
      3'd4: r = sx(longint'({x[31:12], 12'b0}), 32);
      3'd5: r = CSR_EN ? longint'(x[19:15]) : 64'sd0;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [24:0] ins, input logic [2:0] src, input logic [4:0] tag);
    in_valid = v;
    instr    = ins;
    imm_src  = src;
    in_tag   = tag;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({vld32, rdy32, imm32, tag32, ill32} !== {1'b0, 1'b1, 32'h0, 5'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset32: got vld=%b rdy=%b imm=%h tag=%h ill=%b, want 0 1 0 0 0", vld32, rdy32, imm32, tag32, ill32);
    end
    n_cmp++;
    if ({vld64, rdy64, imm64, tag64, ill64} !== {1'b0, 1'b1, 64'h0, 5'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset64: got vld=%b rdy=%b imm=%h tag=%h ill=%b, want 0 1 0 0 0", vld64, rdy64, imm64, tag64, ill64);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_legacy;
    logic [31:0] exp_imm [4] = '{32'h0, 32'h14, 32'h14, 32'h0};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 25'h0000014, 3'(k), 5'(k + 1));
      @(negedge clk);
      n_cmp++;
      if (vld32 !== 1'b1 || imm32 !== exp_imm[k] || tag32 !== 5'(k + 1) || ill32 !== 1'b0) begin
        n_bad++;
        $display("FAIL legacy src=%0d: got vld=%b imm=%h tag=%0d ill=%b, want 1 %h %0d 0", k, vld32, imm32, tag32, ill32, exp_imm[k], k + 1);
      end
    end
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    @(negedge clk);
  endtask

  task automatic test_formats;
    logic [24:0] ins [4] = '{25'h1FFE001, 25'h1FC001D, 25'h02468A1, 25'h12468A1};
    logic [2:0]  src [4] = '{3'd0, 3'd2, 3'd4, 3'd4};
    logic [63:0] e64 [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                             64'h0000_0000_1234_5000, 64'hFFFF_FFFF_9234_5000};
    logic [63:0] e;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ins[k], src[k], 5'(k + 9));
      e = e64[k];
      @(negedge clk);
      n_cmp++;
      if (vld32 !== 1'b1 || imm32 !== e[31:0] || ill32 !== 1'b0) begin
        n_bad++;
        $display("FAIL format32 case %0d: got vld=%b imm=%h ill=%b, want 1 %h 0", k, vld32, imm32, ill32, e[31:0]);
      end
      n_cmp++;
      if (vld64 !== 1'b1 || imm64 !== e || tag64 !== 5'(k + 9)) begin
        n_bad++;
        $display("FAIL format64 case %0d: got vld=%b imm=%h tag=%0d, want 1 %h %0d", k, vld64, imm64, tag64, e, k + 9);
      end
    end
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    @(negedge clk);
  endtask

  task automatic test_illegal_csr;
    logic [2:0]  src [3] = '{3'd6, 3'd7, 3'd5};
    logic [24:0] ins [3];
    logic [63:0] e_imm;
    logic        e_ill;
    ins[0] = 25'($urandom);
    ins[1] = 25'($urandom);
    ins[2] = 25'h0001F00;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e_imm = (k == 2 && CSR_EN) ? 64'h1F : 64'h0;
      e_ill = (k == 2) ? !CSR_EN : 1'b1;
      drive(1'b1, ins[k], src[k], 5'(k + 20));
      @(negedge clk);
      n_cmp++;
      if (vld32 !== 1'b1 || imm32 !== e_imm[31:0] || ill32 !== e_ill || imm64 !== e_imm || ill64 !== e_ill) begin
        n_bad++;
        $display("FAIL illegal_csr src=%0d: got vld=%b imm32=%h imm64=%h ill=%b/%b, want 1 %h %b", src[k], vld32, imm32, imm64, ill32, ill64, e_imm, e_ill);
      end
    end
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c >= 3) begin
        n_cmp++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_in_ready cycle %0d: got %b/%b, want 0", c, rdy32, rdy64);
        end
      end
      drive(1'b1, 25'((idx + 1) << 13), 3'd0, 5'(idx + 1));
      if (rdy32) idx++;
      @(negedge clk);
    end
    n_cmp++;
    if (idx !== 2 || vld32 !== 1'b1 || tag32 !== 5'd1) begin
      n_bad++;
      $display("FAIL bp_accept: got accepted=%0d vld=%b head_tag=%0d, want 2 1 1", idx, vld32, tag32);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (vld32) begin
        n_cmp++;
        if (tag32 !== 5'(got + 1) || imm32 !== 32'(got + 1) || tag64 !== 5'(got + 1)) begin
          n_bad++;
          $display("FAIL bp_order beat %0d: got tag=%0d imm=%h, want tag=%0d imm=%h", got, tag32, imm32, got + 1, got + 1);
        end
        got++;
      end
      if (idx < 4) drive(1'b1, 25'((idx + 1) << 13), 3'd0, 5'(idx + 1));
      else drive(1'b0, 25'h0, 3'd0, 5'd0);
      if (idx < 4 && rdy32) idx++;
      @(negedge clk);
    end
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    n_cmp++;
    if (got !== 4 || vld32 !== 1'b0 || rdy32 !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_drain: got beats=%0d vld=%b rdy=%b, want 4 0 1", got, vld32, rdy32);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 25'h2000, 3'd0, 5'd1);
    @(negedge clk);
    drive(1'b1, 25'h4000, 3'd0, 5'd2);
    @(negedge clk);
    n_cmp++;
    if (vld32 !== 1'b1 || rdy32 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_fill: got vld=%b rdy=%b, want 1 0", vld32, rdy32);
    end
    flush = 1'b1;
    drive(1'b1, 25'h6000, 3'd0, 5'd3);
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (vld32 !== 1'b0 || rdy32 !== 1'b1 || vld64 !== 1'b0 || rdy64 !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_full: got vld=%b rdy=%b, want 0 1", vld32, rdy32);
    end
    drive(1'b1, 25'h8000, 3'd0, 5'd4);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 25'hA000, 3'd0, 5'd5);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    n_cmp++;
    if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_xfer: got vld=%b rdy=%b, want 0 1", vld32, rdy32);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_ghost cycle %0d: got vld=%b tag=%0d, want 0", c, vld32, tag32);
      end
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    drive(1'b1, 25'h1FFE001, 3'd0, 5'd7);
    @(negedge clk);
    drive(1'b1, 25'h1FFE001, 3'd1, 5'd8);
    @(negedge clk);
    drive(1'b0, 25'h0, 3'd0, 5'd0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({vld32, rdy32, imm32, tag32, ill32} !== {1'b0, 1'b1, 32'h0, 5'h0, 1'b0} ||
        {vld64, rdy64, imm64, tag64} !== {1'b0, 1'b1, 64'h0, 5'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: got vld=%b rdy=%b imm=%h tag=%0d ill=%b, want 0 1 0 0 0", vld32, rdy32, imm32, tag32, ill32);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_after: got vld=%b rdy=%b, want 0 1", vld32, rdy32);
    end
  endtask

  task automatic test_stream(input string name, input int n, input int p_in, input int p_out, input int p_fl);
    bit    drain;
    logic  v;
    int    occ;
    beat_t b;
    beat_t h;
    sb.delete();
    for (int c = 0; c < n; c++) begin
      drain = (c >= n - 4);
      v = !drain && ($urandom_range(99) < p_in);
      drive(v, 25'($urandom), 3'($urandom_range(7)), 5'($urandom));
      out_ready = drain || ($urandom_range(99) < p_out);
      flush = !drain && ($urandom_range(99) < p_fl);
      occ = sb.size();
      if (flush) begin
        sb.delete();
      end else begin
        if (occ > 0 && out_ready) void'(sb.pop_front());
        if (v && occ < 2) begin
          b.imm = ref_imm(instr, imm_src);
          b.tag = in_tag;
          b.ill = ref_ill(imm_src);
          sb.push_back(b);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (vld32 !== (sb.size() > 0) || rdy32 !== (sb.size() < 2) || vld64 !== (sb.size() > 0) || rdy64 !== (sb.size() < 2)) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got vld=%b/%b rdy=%b/%b, want occupancy %0d", name, c, vld32, vld64, rdy32, rdy64, sb.size());
      end
      if (sb.size() > 0) begin
        h = sb[0];
        n_cmp++;
        if (imm32 !== h.imm[31:0] || imm64 !== h.imm || tag32 !== h.tag || tag64 !== h.tag || ill32 !== h.ill || ill64 !== h.ill) begin
          n_bad++;
          $display("FAIL %s payload cycle %0d: got imm=%h/%h tag=%0d ill=%b, want %h tag=%0d ill=%b", name, c, imm32, imm64, tag32, ill32, h.imm, h.tag, h.ill);
        end
      end
    end
    flush = 1'b0;
    drive(1'b0, 25'h0, 3'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_formats();
    test_illegal_csr();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_stream("back_to_back", 60, 100, 100, 0);
    test_stream("random_bp", 300, 70, 40, 0);
    test_stream("random_flush", 300, 80, 60, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
